// File: rtl/imm_extend_stage.sv
// imm_extend_stage: immediate extender feeding a 2-entry FIFO.
// Define IMM_EXT_OVF_EN to add the per-entry out_ovf flag for mode 10.
module imm_extend_stage #(
  parameter int XLEN = 32,
  parameter int IMM_W = 17,
  parameter int TAG_W = 5,
  parameter int UPPER_SH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
`ifdef IMM_EXT_OVF_EN
  output logic             out_ovf,
`endif
  output logic [TAG_W-1:0] out_tag
);
`ifdef IMM_EXT_OVF_EN
  localparam int EW = XLEN + TAG_W + 1;
`else
  localparam int EW = XLEN + TAG_W;
`endif
  logic [1:0] cnt;
  logic [EW-1:0] head, tail, newEntry;
  logic [XLEN-1:0] zext, sext, ext;
  logic acc, pop;
  assign zext = {{(XLEN-IMM_W){1'b0}}, in_imm};
  assign sext = {{(XLEN-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign ext = in_mode[1] ? (in_mode[0] ? sext << 2 : zext << UPPER_SH)
                          : (in_mode[0] ? sext : zext);
`ifdef IMM_EXT_OVF_EN
  // any raw bit at or above XLEN-UPPER_SH leaves the word in upper mode
  assign newEntry = {in_mode == 2'b10 && |(in_imm >> (XLEN - UPPER_SH)), in_tag, ext};
  assign out_ovf = head[EW-1];
`else
  assign newEntry = {in_tag, ext};
`endif
  assign in_ready = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign acc = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready && !flush;
  assign out_imm = head[XLEN-1:0];
  assign out_tag = head[XLEN +: TAG_W];
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {1'b0, acc} - {1'b0, pop};
      if (pop && cnt == 2'd2) head <= tail;
      else if (acc && (cnt == 2'd0 || pop)) head <= newEntry;
      if (acc && cnt == 2'd1 && !pop) tail <= newEntry;
    end
  end
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb_imm_extend_stage: directed vectors, queue scoreboard, negedge monitor.
module tb_imm_extend_stage;
  logic clk = 0, reset = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [16:0] in_imm = '0;
  logic [1:0] in_mode = '0;
  logic [4:0] in_tag = '0, out_tag;
  logic [31:0] out_imm;
`ifdef IMM_EXT_OVF_EN
  logic out_ovf;
`endif
  imm_extend_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
`ifdef IMM_EXT_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_tag(out_tag)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, curIdx = 0;
  int q[$];
  bit started = 0, lastAcc = 0, doPop, doAcc;
  logic [16:0] vImm[12] = '{17'h18000, 17'h18000, 17'h18000, 17'h1FFFF, 17'h00001, 17'h0FFFF,
                            17'h10000, 17'h07FFF, 17'h10000, 17'h1FFFF, 17'h0ABCD, 17'h12345};
  logic [1:0] vMode[12] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10,
                            2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11};
  logic [31:0] vExp[12] = '{32'hFFFF8000, 32'h00018000, 32'h80000000, 32'hFFFFFFFC,
                            32'h00010000, 32'hFFFF0000, 32'h00000000, 32'h0001FFFC,
                            32'hFFFF0000, 32'h0001FFFF, 32'h0000ABCD, 32'hFFFC8D14};
`ifdef IMM_EXT_OVF_EN
  logic vOvf[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  // issue side pushes accepted vectors, consume side pops on a handshake
  always @(posedge clk) begin
    lastAcc = 0;
    if (reset || flush) q.delete();
    else begin
      doPop = q.size() > 0 && out_ready;
      doAcc = in_valid && q.size() < 2;
      if (doPop) void'(q.pop_front());
      if (doAcc) q.push_back(curIdx);
      lastAcc = doAcc;
    end
  end
  always @(negedge clk) if (started) begin
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      check("out_imm", out_imm, vExp[q[0]]);
      check("out_tag", 32'(out_tag), 32'(q[0] + 1));
`ifdef IMM_EXT_OVF_EN
      check("out_ovf", 32'(out_ovf), 32'(vOvf[q[0]]));
`endif
    end
  end
  task automatic cycle(input bit v, input int idx, input bit ordy, input bit fl);
    in_valid = v;
    curIdx = idx;
    in_imm = vImm[idx];
    in_mode = vMode[idx];
    in_tag = 5'(idx + 1);
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int idx, input bit ordy);
    int n = 0;
    do begin
      cycle(1, idx, ordy, 0);
      n++;
    end while (!lastAcc && n < 10);
    total++;
    if (!lastAcc) begin
      bad++;
      $display("FAIL send%0d: accepted=0 required=1 within 10 cycles", idx);
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    started = 1;
    cycle(0, 0, 0, 0);
    reset = 0;
    check("rst_imm", out_imm, 32'h0);
    check("rst_tag", 32'(out_tag), 32'h0);
    for (int i = 0; i < 12; i++) send(i, 1);
    repeat (2) cycle(0, 0, 1, 0);
    send(0, 0);
    send(1, 0);
    repeat (3) cycle(1, 2, 0, 0);
    send(2, 1);
    repeat (3) cycle(0, 0, 1, 0);
    send(3, 0);
    send(4, 0);
    cycle(1, 5, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    send(6, 1);
    cycle(0, 0, 1, 0);
    send(10, 0);
    cycle(1, 11, 1, 1);
    cycle(0, 0, 1, 0);
    send(7, 0);
    send(8, 0);
    reset = 1;
    cycle(0, 0, 0, 0);
    reset = 0;
    check("rst2_imm", out_imm, 32'h0);
    check("rst2_tag", 32'(out_tag), 32'h0);
    send(9, 1);
    repeat (2) cycle(0, 0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
